// File: rtl/cc_frame_feeder.sv
// rtl/cc_frame_feeder.sv - single-buffer frame feeder ahead of the cross-correlation core
module cc_frame_feeder #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 12800,
    parameter int ADDR_W    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             cc_start,
    output logic [WIDTH-1:0] cc_m0,
    output logic [WIDTH-1:0] cc_m1,
    input  logic             cc_done,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    // S_START is the prefetch cycle for pair 0; the start pulse itself is
    // registered and becomes visible one cycle later, together with pair 0.
    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [2*WIDTH-1:0] mem [0:FRAME_LEN-1];
    logic [2*WIDTH-1:0] rd_data;
    logic               accept;
    logic               rd_en;

    assign accept = (state == S_FILL) && in_valid && in_ready;
    assign rd_en  = (state == S_START) || (state == S_STREAM);
    assign cc_m0  = rd_data[2*WIDTH-1:WIDTH];
    assign cc_m1  = rd_data[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; cc_done only matters once the whole frame has left.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (accept && (wr_ptr == LAST_ADDR)) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (rd_ptr == LAST_ADDR) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cc_done) begin
                    state_next = S_FILL;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // Write pointer advances per accepted pair and wraps at the frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (accept) begin
            if (wr_ptr == LAST_ADDR) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Read pointer walks the frame once per prefetch+stream pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            if (rd_ptr == LAST_ADDR) begin
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Frame buffer write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // Registered read port doubles as the correlator sample register; it
    // freezes outside prefetch/stream so WAIT keeps the last pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Handshake, start pulse and busy flag are all registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            cc_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            in_ready <= (state_next == S_FILL);
            cc_start <= (state == S_START);
            busy     <= (state_next != S_FILL);
        end
    end

    // Completed-frame counter, bumped on the edge that leaves WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if ((state == S_WAIT) && cc_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cc_frame_feeder.sv
// tb/tb_cc_frame_feeder.sv - directed table and sequence bench for cc_frame_feeder
module tb_cc_frame_feeder;

    localparam int WIDTH     = 16;
    localparam int FRAME_LEN = 8;
    localparam int ADDR_W    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             cc_start;
    logic [WIDTH-1:0] cc_m0;
    logic [WIDTH-1:0] cc_m1;
    logic             cc_done;
    logic             busy;
    logic [15:0]      frame_cnt;

    always #5 clk = ~clk;

    cc_frame_feeder #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .cc_start  (cc_start),
        .cc_m0     (cc_m0),
        .cc_m1     (cc_m1),
        .cc_done   (cc_done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic        done;
        logic        rdy;
        logic        st;
        logic [15:0] m0;
        logic [15:0] m1;
        logic        bsy;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic v, input int a, input int b, input logic done,
                        input logic rdy, input logic st, input int m0, input int m1,
                        input logic bsy, input int fc);
        vec_t e;
        e.v = v; e.a = 16'(a); e.b = 16'(b); e.done = done;
        e.rdy = rdy; e.st = st; e.m0 = 16'(m0); e.m1 = 16'(m1);
        e.bsy = bsy; e.fc = 16'(fc);
        tbl.push_back(e);
    endtask

    // Called at a negedge with the DUT in FILL; returns at the negedge after the last accept.
    task automatic feed(input int base_a, input int base_b, input bit gapped, input logic done_lvl);
        int j   = 0;
        int cyc = 0;
        bit tog = 1'b0;
        bit r;
        while (j < FRAME_LEN && cyc < 40) begin
            tog      = gapped ? ~tog : 1'b1;
            r        = in_ready;
            in_valid = tog;
            in_a     = tog ? 16'(base_a + j) : 16'hDEAD;
            in_b     = tog ? 16'(base_b + j) : 16'hBEEF;
            cc_done  = done_lvl;
            @(posedge clk);
            if (tog && r) j++;
            cyc++;
            @(negedge clk);
        end
        chk("feed_accept_count", 32'(j), 32'(FRAME_LEN));
        in_valid = 1'b1;
        in_a     = 16'd999;
        in_b     = 16'd999;
        cc_done  = 1'b0;
    endtask

    task automatic stream_check(input int base_a, input int base_b, input int stop_at);
        chk("post_fill_in_ready", 32'(in_ready), 32'd0);
        chk("post_fill_start", 32'(cc_start), 32'd0);
        chk("post_fill_busy", 32'(busy), 32'd1);
        for (int k = 0; k < FRAME_LEN; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stream%0d_start", k), 32'(cc_start), 32'(k == 0));
            chk($sformatf("stream%0d_m0", k), 32'(cc_m0), 32'(base_a + k));
            chk($sformatf("stream%0d_m1", k), 32'(cc_m1), 32'(base_b + k));
            chk($sformatf("stream%0d_busy", k), 32'(busy), 32'd1);
            if (k == stop_at) return;
        end
    endtask

    task automatic finish_frame(input int exp_fc);
        @(posedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_frame_cnt", 32'(frame_cnt), 32'(exp_fc - 1));
        cc_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cc_done = 1'b0;
        chk("done_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Frame 1: pairs (i,100+i), 999 backpressure, done pulse mid-stream ignored,
        // done 5 cycles into WAIT. Frame 2: pairs (20+i,200+i), immediate done.
        push(1, 0, 100, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(1, i, 100 + i, 0, (i < 7), 0, 0, 0, (i == 7), 0);
        push(1, 999, 999, 0, 0, 1, 0, 100, 1, 0);
        for (int k = 1; k < 8; k++) push(1, 999, 999, (k == 3), 0, 0, k, 100 + k, 1, 0);
        for (int w = 0; w < 4; w++) push(1, 999, 999, 0, 0, 0, 7, 107, 1, 0);
        push(1, 999, 999, 1, 1, 0, 7, 107, 0, 1);
        for (int i = 0; i < 8; i++) push(1, 20 + i, 200 + i, 0, (i < 7), 0, 7, 107, (i == 7), 1);
        push(0, 0, 0, 0, 0, 1, 20, 200, 1, 1);
        for (int k = 1; k < 8; k++) push(0, 0, 0, 0, 0, 0, 20 + k, 200 + k, 1, 1);
        push(0, 0, 0, 1, 1, 0, 27, 207, 0, 2);

        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        cc_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_start", 32'(cc_start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_m0", 32'(cc_m0), 32'd0);

        foreach (tbl[n]) begin
            in_valid = tbl[n].v;
            in_a     = tbl[n].a;
            in_b     = tbl[n].b;
            cc_done  = tbl[n].done;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", n), 32'(in_ready), 32'(tbl[n].rdy));
            chk($sformatf("vec%0d_start", n), 32'(cc_start), 32'(tbl[n].st));
            chk($sformatf("vec%0d_m0", n), 32'(cc_m0), 32'(tbl[n].m0));
            chk($sformatf("vec%0d_m1", n), 32'(cc_m1), 32'(tbl[n].m1));
            chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(tbl[n].bsy));
            chk($sformatf("vec%0d_frame_cnt", n), 32'(frame_cnt), 32'(tbl[n].fc));
        end
        in_valid = 1'b0;
        cc_done  = 1'b0;

        // Frame 3: gapped input with junk between valids, stale cc_done held high during fill.
        feed(40, 140, 1'b1, 1'b1);
        stream_check(40, 140, -1);
        finish_frame(3);

        // Frame 4: reset at stream index 3, then a fresh frame from pair 0.
        feed(60, 160, 1'b0, 1'b0);
        stream_check(60, 160, 3);
        rst = 1'b0;
        #1;
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        chk("midreset_start", 32'(cc_start), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_m0", 32'(cc_m0), 32'd0);
        chk("midreset_m1", 32'(cc_m1), 32'd0);
        chk("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        feed(80, 180, 1'b0, 1'b0);
        stream_check(80, 180, -1);
        finish_frame(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cc_frame_feeder.md
# cc_frame_feeder

Upstream stage of the cross-correlation core `cc_1`. It accepts paired samples from two channels through a valid/ready handshake and buffers one frame of `FRAME_LEN` pairs. It then pulses `start` to the correlator and streams the frame into its `m0`/`m1` inputs, one pair per cycle. It holds off new input until the correlator reports `done`.

## Interface
Parameters:
- `WIDTH`, 16: sample width, both channels.
- `FRAME_LEN`, 12800: sample pairs per frame; must be at least 2.
- `ADDR_W`, 14: buffer address width; 2^ADDR_W must be at least FRAME_LEN.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `in_valid`  in  1: input pair valid.
- `in_ready`  out  1: feeder accepts a pair this cycle.
- `in_a`  in  WIDTH: channel-0 sample.
- `in_b`  in  WIDTH: channel-1 sample.
- `cc_start`  out  1: one-cycle start pulse to the correlator.
- `cc_m0`  out  WIDTH: channel-0 sample to the correlator.
- `cc_m1`  out  WIDTH: channel-1 sample to the correlator.
- `cc_done`  in  1: correlator finished; level input.
- `busy`  out  1: frame is being streamed or awaiting `cc_done`.
- `frame_cnt`  out  16: completed frames, wrapping modulo 2^16.

## Operation
- Buffer: one FRAME_LEN x (2*WIDTH) RAM holding `{in_a, in_b}`. Reads are registered. Single buffer; no ping-pong.
- States: FILL, START, STREAM, WAIT.
- FILL:
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready`: write the pair at `wr_ptr`, then increment `wr_ptr`.
  - When the accepted pair is number FRAME_LEN (`wr_ptr`=FRAME_LEN-1): clear `wr_ptr` to 0, deassert `in_ready` on the next cycle, go to START.
- START (1 cycle): `cc_start`=1; `cc_m0`/`cc_m1` carry pair 0. Go to STREAM.
- STREAM: in the k-th cycle after START (k=1..FRAME_LEN-1), `cc_m0`/`cc_m1` carry pair k. After pair FRAME_LEN-1, go to WAIT.
- WAIT: `cc_m0`/`cc_m1` hold pair FRAME_LEN-1. On the first cycle with `cc_done`=1: increment `frame_cnt`, go to FILL.
- `cc_done` is ignored outside WAIT. A `cc_done` still high from the previous frame cannot cause an early exit, because FILL needs at least FRAME_LEN cycles.
- `busy`=1 in START, STREAM and WAIT; 0 in FILL.
- `in_a`/`in_b` are ignored whenever `in_ready`=0, even if `in_valid`=1. Upstream must hold data until it is accepted.
- Reset (`rst` low, at any time, including mid-FILL or mid-STREAM):
  - state goes to FILL, `wr_ptr`=0, read pointer=0, `frame_cnt`=0;
  - `in_ready`=0, `cc_start`=0, `busy`=0, `cc_m0`=0, `cc_m1`=0;
  - buffer contents are not cleared; the partial frame is discarded.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `in_ready` rises on the first `clk` edge after `rst` deasserts.
- The pair accepted at edge N is in the buffer and readable from edge N+1.
- The cycle after the edge that accepts the last pair, `in_ready`=0.
- `cc_start` asserts exactly 2 cycles after the edge accepting the last pair. The extra cycle is the RAM read latency for pair 0, prefetched on FILL exit.
- Streaming is gapless: FRAME_LEN consecutive cycles, starting with the `cc_start` cycle.
- WAIT to FILL:
  - `in_ready`=1 the cycle after `cc_done` is sampled high;
  - `frame_cnt` updates on the same edge;
  - `busy` falls on the same edge.
- Minimum frame period: FRAME_LEN (fill) + 1 (prefetch) + FRAME_LEN (stream) + 1 (done sampling) cycles, plus correlator latency.

## Test plan
- Reset, FRAME_LEN=8: after `rst` release, `in_ready`=1 one cycle later; `cc_start`=0, `busy`=0, `frame_cnt`=0.
- Fill and stream, FRAME_LEN=8: feed pairs (i, 100+i) for i=0..7 with `in_valid` held 1.
  - `in_ready`=0 one cycle after pair 7 is accepted.
  - `cc_start` pulses one cycle later with `cc_m0`=0, `cc_m1`=100.
  - The next 7 cycles give `cc_m0`=1..7, `cc_m1`=101..107.
  - `busy`=1 throughout.
- Gapped input: toggle `in_valid` every cycle and drive junk data while `in_valid`=0. The streamed order is still 0..7 / 100..107 with no junk.
- Backpressure: hold `in_valid`=1 with value 999 during STREAM and WAIT. Nothing is written; the next frame streams only the pairs fed after `in_ready` returns.
- Done handling:
  - `cc_done` pulsed during STREAM is ignored;
  - `cc_done` high 5 cycles into WAIT gives `frame_cnt` 0 then 1, `busy`=0, and `in_ready`=1 on the next edge;
  - a second full frame increments `frame_cnt` to 2.
- Reset mid-operation: assert `rst` low at stream index 3. All outputs reset immediately. After release, a fresh 8-pair frame streams correctly from pair 0.
